// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the shared 32x8 data memory: one access per
// three cycles (IDLE grant, ACCESS drive memory, DONE acknowledge).

module dmem_arbiter_lane #(
    parameter int DATA_W = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              sel,
    input  logic              in_access,
    input  logic              in_done,
    input  logic [DATA_W-1:0] mem_rd,
    output logic              ack,
    output logic [DATA_W-1:0] rdata
);
    // Read data is captured even for writes, giving read-before-write for free.
    always_ff @(posedge Clk) begin
        if (Reset)                 rdata <= '0;
        else if (in_access && sel) rdata <= mem_rd;
    end

    assign ack = in_done & sel & ~Reset;
endmodule

module dmem_arbiter #(
    parameter int ADDR_W      = 5,
    parameter int DATA_W      = 8,
    parameter int ROUND_ROBIN = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Req0,
    input  logic              We0,
    input  logic [ADDR_W-1:0] Addr0,
    input  logic [DATA_W-1:0] Wdata0,
    output logic              Ack0,
    output logic [DATA_W-1:0] Rdata0,
    input  logic              Req1,
    input  logic              We1,
    input  logic [ADDR_W-1:0] Addr1,
    input  logic [DATA_W-1:0] Wdata1,
    output logic              Ack1,
    output logic [DATA_W-1:0] Rdata1,
    output logic              Mem_We,
    output logic [ADDR_W-1:0] Mem_Address,
    output logic [DATA_W-1:0] Mem_Data_in,
    input  logic [DATA_W-1:0] Mem_Data_out,
    output logic              Busy
);
    localparam int NUM_PORTS = 2;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t state, state_nxt;

    logic [NUM_PORTS-1:0]             req_v, we_v, sel_v, ack_v;
    logic [NUM_PORTS-1:0][ADDR_W-1:0] addr_v;
    logic [NUM_PORTS-1:0][DATA_W-1:0] wdata_v, rdata_v;

    logic              gnt_id;
    logic              lat_id, lat_we, last_gnt;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              in_access, in_done;

    assign req_v   = {Req1, Req0};
    assign we_v    = {We1, We0};
    assign addr_v  = {Addr1, Addr0};
    assign wdata_v = {Wdata1, Wdata0};

    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|req_v) state_nxt = ACCESS;
            ACCESS:  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // On a tie the round-robin pointer favours the port not granted last.
    always_comb begin
        gnt_id = 1'b0;
        if (req_v == 2'b10)
            gnt_id = 1'b1;
        else if (req_v == 2'b11 && ROUND_ROBIN != 0)
            gnt_id = ~last_gnt;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            lat_id    <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            last_gnt  <= 1'b1;
        end else begin
            if (state == IDLE && |req_v) begin
                lat_id    <= gnt_id;
                lat_we    <= we_v[gnt_id];
                lat_addr  <= addr_v[gnt_id];
                lat_wdata <= wdata_v[gnt_id];
            end
            if (state == DONE) last_gnt <= lat_id;
        end
    end

    always_comb begin
        in_access = (state == ACCESS);
        in_done   = (state == DONE);
        Busy      = (state != IDLE);
        Mem_We    = in_access && lat_we && !Reset;
    end

    // Address/data only change on a grant, so they hold outside ACCESS.
    assign Mem_Address = lat_addr;
    assign Mem_Data_in = lat_wdata;
    assign sel_v       = lat_id ? 2'b10 : 2'b01;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_lane
        dmem_arbiter_lane #(.DATA_W(DATA_W)) u_lane (
            .Clk       (Clk),
            .Reset     (Reset),
            .sel       (sel_v[i]),
            .in_access (in_access),
            .in_done   (in_done),
            .mem_rd    (Mem_Data_out),
            .ack       (ack_v[i]),
            .rdata     (rdata_v[i])
        );
    end

    assign Ack0   = ack_v[0];
    assign Ack1   = ack_v[1];
    assign Rdata0 = rdata_v[0];
    assign Rdata1 = rdata_v[1];
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic, all checked
// every cycle against a transaction-level model with its own memory image.

module tb_dmem_arbiter;
    localparam int AW = 5;
    localparam int DW = 8;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          Req0, We0, Req1, We1;
    logic [AW-1:0] Addr0, Addr1;
    logic [DW-1:0] Wdata0, Wdata1;

    logic          Ack0, Ack1, Mem_We, Busy;
    logic [DW-1:0] Rdata0, Rdata1, Mem_Data_in, Mem_Data_out;
    logic [AW-1:0] Mem_Address;

    logic          f_ack0, f_ack1, f_we, f_busy;
    logic [DW-1:0] f_rd0, f_rd1, f_din, f_dout;
    logic [AW-1:0] f_addr;

    logic [DW-1:0] dmem    [32] = '{default: '0};
    logic [DW-1:0] dmem_fp [32] = '{default: '0};

    always #5 Clk = ~Clk;

    always @(posedge Clk) if (Mem_We) dmem[Mem_Address] <= Mem_Data_in;
    assign Mem_Data_out = dmem[Mem_Address];
    always @(posedge Clk) if (f_we) dmem_fp[f_addr] <= f_din;
    assign f_dout = dmem_fp[f_addr];

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ROUND_ROBIN(1)) dut (
        .Clk(Clk), .Reset(Reset),
        .Req0(Req0), .We0(We0), .Addr0(Addr0), .Wdata0(Wdata0), .Ack0(Ack0), .Rdata0(Rdata0),
        .Req1(Req1), .We1(We1), .Addr1(Addr1), .Wdata1(Wdata1), .Ack1(Ack1), .Rdata1(Rdata1),
        .Mem_We(Mem_We), .Mem_Address(Mem_Address), .Mem_Data_in(Mem_Data_in),
        .Mem_Data_out(Mem_Data_out), .Busy(Busy));

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ROUND_ROBIN(0)) dut_fp (
        .Clk(Clk), .Reset(Reset),
        .Req0(Req0), .We0(We0), .Addr0(Addr0), .Wdata0(Wdata0), .Ack0(f_ack0), .Rdata0(f_rd0),
        .Req1(Req1), .We1(We1), .Addr1(Addr1), .Wdata1(Wdata1), .Ack1(f_ack1), .Rdata1(f_rd1),
        .Mem_We(f_we), .Mem_Address(f_addr), .Mem_Data_in(f_din),
        .Mem_Data_out(f_dout), .Busy(f_busy));

    int n_chk = 0;
    int n_fail = 0;

    // Transaction-level model: an access occupies three cycles from its grant.
    int            cyc = 0;
    bit            act = 0;
    int            g_cyc;
    bit            t_port, t_we, last_gnt;
    logic [AW-1:0] t_addr, exp_maddr;
    logic [DW-1:0] t_wdata, exp_mdin;
    logic [DW-1:0] exp_rd  [2];
    logic [DW-1:0] ref_mem [32];
    bit            done    [2];
    bit            r_req   [2];
    int            ack_port_q[$];
    int            ack_cyc_q[$];
    int            fp_a0, fp_a1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic set_port(input int p, input bit r, input bit w,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (p == 0) begin Req0 = r; We0 = w; Addr0 = a; Wdata0 = d; end
        else        begin Req1 = r; We1 = w; Addr1 = a; Wdata1 = d; end
        r_req[p] = r;
    endtask

    task automatic cycle_chk();
        bit       was_act;
        int       ph;
        bit [1:0] rq;
        @(negedge Clk);
        if (f_ack0) fp_a0++;
        if (f_ack1) fp_a1++;
        if (Reset) begin
            chk("we_in_reset",   32'(Mem_We), 32'(0));
            chk("ack0_in_reset", 32'(Ack0), 32'(0));
            chk("ack1_in_reset", 32'(Ack1), 32'(0));
            act = 0; last_gnt = 1;
            exp_rd[0] = '0; exp_rd[1] = '0; exp_maddr = '0; exp_mdin = '0;
        end else begin
            was_act = act;
            ph = act ? cyc - g_cyc : 0;
            chk("busy",   32'(Busy),   32'(act));
            chk("mem_we", 32'(Mem_We), 32'(act && ph == 1 && t_we));
            chk("ack0",   32'(Ack0),   32'(act && ph == 2 && !t_port));
            chk("ack1",   32'(Ack1),   32'(act && ph == 2 && t_port));
            chk("mem_addr", 32'(Mem_Address), 32'(exp_maddr));
            chk("mem_din",  32'(Mem_Data_in), 32'(exp_mdin));
            chk("rdata0", 32'(Rdata0), 32'(exp_rd[0]));
            chk("rdata1", 32'(Rdata1), 32'(exp_rd[1]));
            if (act && ph == 1) begin
                exp_rd[t_port] = ref_mem[t_addr];
                if (t_we) ref_mem[t_addr] = t_wdata;
            end
            if (act && ph == 2) begin
                act = 0; last_gnt = t_port; done[t_port] = 1;
                ack_port_q.push_back(int'(t_port));
                ack_cyc_q.push_back(cyc);
            end
            rq = {Req1, Req0};
            if (!was_act && rq != 2'b00) begin
                t_port  = (rq == 2'b11) ? !last_gnt : rq[1];
                t_we    = t_port ? We1 : We0;
                t_addr  = t_port ? Addr1 : Addr0;
                t_wdata = t_port ? Wdata1 : Wdata0;
                act = 1; g_cyc = cyc;
                exp_maddr = t_addr; exp_mdin = t_wdata;
            end
        end
        cyc++;
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        Reset = 1'b1;
        repeat (n) cycle_chk();
        Reset = 1'b0;
    endtask

    task automatic acc(input int p, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        set_port(p, 1'b1, w, a, d);
        for (int k = 0; k < 12; k++) begin
            cycle_chk();
            if (done[p]) break;
        end
        chk("acc_done", 32'(done[p]), 32'(1));
        done[p] = 0;
        set_port(p, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic rand_req(input int p);
        logic [AW-1:0] a;
        a = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
        set_port(p, 1'b1, 1'($urandom_range(0, 1)), a, 8'($urandom_range(0, 255)));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int start_c, n_ack;
        for (int i = 0; i < 32; i++) ref_mem[i] = '0;
        done[0] = 0; done[1] = 0;
        set_port(0, 1'b0, 1'b0, '0, '0);
        set_port(1, 1'b0, 1'b0, '0, '0);
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        do_reset(2);
        cycle_chk();

        // Write then read back, then overwrite returning the old word.
        start_c = cyc;
        acc(0, 1'b1, 5'd5, 8'hA5);
        chk("write_latency", 32'(ack_cyc_q[$] - start_c), 32'(2));
        start_c = cyc;
        acc(0, 1'b0, 5'd5, 8'h00);
        chk("read_latency", 32'(ack_cyc_q[$] - start_c), 32'(2));
        cycle_chk();
        chk("read_held", 32'(Rdata0), 32'(8'hA5));
        acc(0, 1'b1, 5'd5, 8'h3C);
        chk("read_before_write", 32'(Rdata0), 32'(8'hA5));

        // Both ports hold requests: round-robin alternates, fixed priority starves port 1.
        do_reset(1);
        ack_port_q.delete(); ack_cyc_q.delete();
        fp_a0 = 0; fp_a1 = 0;
        set_port(0, 1'b1, 1'b0, 5'd1, '0);
        set_port(1, 1'b1, 1'b0, 5'd5, '0);
        for (int k = 0; k < 40 && ack_port_q.size() < 6; k++) begin
            done[0] = 0; done[1] = 0;
            cycle_chk();
        end
        done[0] = 0; done[1] = 0;
        set_port(0, 1'b0, 1'b0, '0, '0);
        set_port(1, 1'b0, 1'b0, '0, '0);
        chk("rr_count", 32'(ack_port_q.size()), 32'(6));
        for (int i = 0; i < ack_port_q.size(); i++) begin
            chk("rr_order", 32'(ack_port_q[i]), 32'(i % 2));
            if (i > 0) chk("rr_spacing", 32'(ack_cyc_q[i] - ack_cyc_q[i-1]), 32'(3));
        end
        chk("fp_ack0_count", 32'(fp_a0), 32'(6));
        chk("fp_ack1_count", 32'(fp_a1), 32'(0));

        // Port 1 write to the top address; port 0 arrives during its ACCESS.
        cycle_chk();
        set_port(1, 1'b1, 1'b1, 5'd31, 8'hFF);
        cycle_chk();
        set_port(0, 1'b1, 1'b0, 5'd31, '0);
        for (int k = 0; k < 12 && !done[0]; k++) begin
            if (done[1]) begin done[1] = 0; set_port(1, 1'b0, 1'b0, '0, '0); end
            cycle_chk();
        end
        chk("late_req_done", 32'(done[0]), 32'(1));
        done[0] = 0;
        set_port(0, 1'b0, 1'b0, '0, '0);
        n_ack = ack_port_q.size();
        chk("order_p1_first", 32'(ack_port_q[n_ack-2]), 32'(1));
        chk("order_p0_next",  32'(ack_port_q[n_ack-1]), 32'(0));
        chk("p0_reads_p1_write", 32'(Rdata0), 32'(8'hFF));

        // Reset during the ACCESS cycle of a write suppresses it.
        acc(1, 1'b1, 5'd2, 8'h11);
        n_ack = ack_port_q.size();
        set_port(1, 1'b1, 1'b1, 5'd2, 8'h77);
        cycle_chk();
        set_port(1, 1'b0, 1'b0, '0, '0);
        do_reset(1);
        cycle_chk();
        chk("abort_no_ack", 32'(ack_port_q.size()), 32'(n_ack));
        acc(1, 1'b0, 5'd2, 8'h00);
        chk("abort_unchanged", 32'(Rdata1), 32'(8'h11));

        // Quiet bench.
        repeat (20) cycle_chk();

        // Random traffic with occasional resets.
        for (int k = 0; k < 3000; k++) begin
            Reset = ($urandom_range(0, 79) == 0);
            for (int p = 0; p < 2; p++) begin
                if (done[p]) begin
                    done[p] = 0;
                    if ($urandom_range(0, 1) == 1) rand_req(p);
                    else set_port(p, 1'b0, 1'b0, '0, '0);
                end else if (!r_req[p] && $urandom_range(0, 2) == 0) begin
                    rand_req(p);
                end
            end
            cycle_chk();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter and access sequencer in front of the 32x8 data memory.
- Lets the CPU load/store unit (port 0) and the program/debug loader (port 1) share the single memory port.
- Arbitrates between them, drives the memory's address, data and write-enable for exactly one cycle per access, and returns read data with a one-cycle acknowledge.
- Sits between the CPU core/loader and the Data_Memory instance.

Parameters:
- ADDR_W, 5, memory address width (32 words).
- DATA_W, 8, data word width.
- ROUND_ROBIN, 1, 1 = alternate priority after each grant; 0 = fixed priority to port 0.

Ports:
- Clk  input  1  system clock, all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Req0  input  1  port 0 (CPU) access request; held high until Ack0.
- We0  input  1  port 0 write (1) / read (0); valid with Req0.
- Addr0  input  ADDR_W  port 0 word address.
- Wdata0  input  DATA_W  port 0 write data.
- Ack0  output  1  one-cycle pulse: port 0 access complete.
- Rdata0  output  DATA_W  port 0 read data; valid with Ack0, held until next Ack0.
- Req1, We1, Addr1, Wdata1, Ack1, Rdata1: same as port 0, for port 1 (loader).
- Mem_We  output  1  memory write enable.
- Mem_Address  output  ADDR_W  memory address.
- Mem_Data_in  output  DATA_W  memory write data.
- Mem_Data_out  input  DATA_W  memory combinational read data at Mem_Address.
- Busy  output  1  high whenever state is not IDLE.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high. Ports are named Clk and Reset.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - Req0/Req1 are sampled here only.
  - If neither is high, stay in IDLE.
  - If exactly one is high, grant it.
  - If both are high:
    - ROUND_ROBIN=1: grant the port not granted last (Last_Gnt pointer).
    - ROUND_ROBIN=0: grant port 0.
  - On a grant: latch the winner's We/Addr/Wdata and winner id into internal registers, then go to ACCESS.
- ACCESS (exactly 1 cycle):
  - Mem_Address = latched Addr.
  - Mem_Data_in = latched Wdata.
  - Mem_We = latched We.
  - Mem_Data_out is captured into the winner's Rdata register at the end of the cycle.
  - Then go to DONE.
- DONE (1 cycle):
  - Winner's Ack is high; the other Ack is low.
  - Last_Gnt updates to the winner.
  - Then go to IDLE.
- Latency: Req seen in IDLE at cycle N, Ack high in cycle N+2. Minimum spacing between Acks is 3 cycles. Throughput is 1 access per 3 cycles.
- Read-before-write: a write's Rdata returns the word's previous contents, captured in the same ACCESS cycle as the write.
- Mem outputs outside ACCESS:
  - Mem_We = 0.
  - Mem_Address and Mem_Data_in hold their last value (0 after reset).
- Handshake rules:
  - A requester keeps Req/We/Addr/Wdata stable until it sees Ack.
  - It drops Req at the edge ending the Ack cycle unless it has another request.
  - A Req still high when IDLE is re-entered is a new request.
  - Request inputs are ignored while in ACCESS or DONE.
- Starvation: with ROUND_ROBIN=1 and both ports requesting continuously, grants strictly alternate.
- Reset values:
  - State = IDLE; Ack0 = Ack1 = 0; Busy = 0.
  - Rdata0 = Rdata1 = 0.
  - Mem_We = 0; Mem_Address = 0; Mem_Data_in = 0.
  - Last_Gnt = 1, so port 0 wins the first tie.
- Reset mid-operation: reset in ACCESS or DONE aborts to IDLE with no Ack.
  - A write whose ACCESS cycle coincides with Reset is suppressed: Mem_We forced 0.
  - An aborted request must be re-presented and is re-arbitrated normally.
- Address range: addresses are full ADDR_W range, no wrap handling needed. Address 31 is valid.

Test Plan:
- Reset, then Req0=1, We0=1, Addr0=5, Wdata0=0xA5 -> Mem_We=1 with Mem_Address=5 exactly one cycle (cycle 1), Ack0 in cycle 2, Busy high cycles 1-2.
- Port 0 read Addr0=5 after the above -> Ack0 two cycles after request, Rdata0=0xA5 held after Ack0 drops. Then port 0 write 0x3C to addr 5 -> Rdata0=0xA5 (old value).
- Req0 and Req1 both held high for 6 accesses, ROUND_ROBIN=1 -> Acks in order 0,1,0,1,0,1, 3 cycles apart. Repeat with ROUND_ROBIN=0 and Req0 held -> only Ack0 pulses.
- Port 1 write 0xFF to addr 31 while Req0 rises during ACCESS -> port 1 completes uninterrupted; port 0 granted in next IDLE; Mem_Address=31 during port 1 ACCESS.
- Reset asserted during ACCESS of a port 1 write of 0x77 to addr 2 -> Mem_We=0 that cycle, no Ack1, next cycle Busy=0. A subsequent read of addr 2 returns the unchanged prior value.
- Idle bench with no requests for 20 cycles -> Mem_We stays 0, Ack0=Ack1=0, Busy=0.
